updown_counter_param: RTL

- Parametrised synchronous up/down counter. Successor to the fixed 4-bit down counter with load-to-all-ones.
- Adds the following over that block:
  - generic width and programmable upper bound (modulus);
  - direction select;
  - load of an arbitrary value;
  - three end-of-count modes: wrap, saturate, one-shot;
  - a registered terminal-count pulse and status flags.
- Used as the general timer/tick/index counter in datapath and control blocks.

---
 rtl/counter_pkg.sv | 19 +
 rtl/updown_counter_param.sv | 97 +++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the parametrised up/down counter.
// Mode select values and one-shot FSM state encoding.
package counter_pkg;

    // End-of-count behaviour selected by the mode input
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // One-shot state: counting, or finished and waiting for load/reset
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with programmable bound,
// load, and wrap / saturate / one-shot end-of-count handling.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             at_zero,
    output logic             at_max,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    state_e           st;
    logic [WIDTH-1:0] ld_clamp;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] wrap_val;
    logic             at_term;
    logic             is_oneshot;

    // Out-of-range loads saturate at the bound so q never leaves 0..MAX_VAL
    assign ld_clamp = (ld_val > MAX_Q) ? MAX_Q : ld_val;

    // Terminal value depends on direction: top when counting up, zero when down
    assign at_term = dir ? (q == MAX_Q) : (q == '0);

    // Ordinary step and the value a rollover jumps to
    assign step_val = dir ? (q + ONE_Q) : (q - ONE_Q);
    assign wrap_val = dir ? '0 : MAX_Q;

    assign is_oneshot = (mode == MODE_ONESHOT);

    // Status flags follow q with no added latency
    assign at_zero = (q == '0);
    assign at_max  = (q == MAX_Q);

    // Count register, terminal pulse and one-shot FSM, priority rst > ld > en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= RST_Q;
            tc   <= 1'b0;
            done <= 1'b0;
            st   <= ST_RUN;
        end else if (ld) begin
            q    <= ld_clamp;
            tc   <= 1'b0;
            done <= 1'b0;
            st   <= ST_RUN;
        end else begin
            // Leaving one-shot mode releases a finished FSM; the
            // current mode then governs this same edge.
            if (!is_oneshot) begin
                st   <= ST_RUN;
                done <= 1'b0;
            end
            if (!en) begin
                tc <= 1'b0;
            end else if (is_oneshot && st == ST_DONE) begin
                tc <= 1'b0;
            end else if (!at_term) begin
                q  <= step_val;
                tc <= 1'b0;
            end else begin
                tc <= 1'b1;
                unique case (mode)
                    MODE_SAT: begin
                    end
                    MODE_ONESHOT: begin
                        st   <= ST_DONE;
                        done <= 1'b1;
                    end
                    MODE_WRAP, MODE_RSVD: begin
                        q <= wrap_val;
                    end
                    default: begin
                        q <= wrap_val;
                    end
                endcase
            end
        end
    end

endmodule
